// File: rtl/franco_xor_pkg.sv
// Shared definitions for the serial XOR cipher: default word width, FSM states and
// counter sizing.
package franco_xor_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE,
      LOAD_KEY,
      LOAD_MSG,
      EMIT
   } state_t;

   // Counter must be able to hold 0..width.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sipo_loader.sv
// Serial-in parallel-out shift register with bit counter; full pulses on the shift that
// completes a word.
module sipo_loader
   import franco_xor_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift,
   input  logic             clear,
   input  logic             din,
   output logic [WIDTH-1:0] word,
   output logic             full
);

   localparam int unsigned CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] word_q;
   logic [CW-1:0]    cnt_q;

   assign word = word_q;
   assign full = shift && (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else if (shift) begin
         word_q <= {word_q[WIDTH-2:0], din};
         cnt_q  <= full ? '0 : cnt_q + CW'(1);
      end else if (clear) begin
         word_q <= '0;
         cnt_q  <= '0;
      end
   end

endmodule

// File: rtl/franco_xor_top.sv
// Serial XOR cipher: shift in key and message, shift out message ^ key MSB first with
// one-cycle start/end markers. The key is retained across messages.
module franco_xor_top
   import franco_xor_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic iClk,
   input  logic iRst,
   input  logic iEn,
   input  logic iLoad_key,
   input  logic iLoad_msg,
   input  logic iSerial_in,
   output logic oSerial_out,
   output logic oSerial_start,
   output logic oSerial_end
);

   localparam int unsigned CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    idx_q, idx_d;
   logic             key_valid_q, key_valid_d;
   logic             out_q, out_d;
   logic             start_q, start_d;
   logic             end_q, end_d;

   logic             loading;
   logic             key_shift, msg_shift, key_clr, msg_clr;
   logic             key_full, msg_full;
   logic [WIDTH-1:0] key_word, msg_word, cipher;

   // Shift/abort decisions are kept outside the FSM block so full never loops back.
   assign loading   = iEn && (state_q != EMIT);
   assign key_shift = loading && iLoad_key;
   assign msg_shift = loading && !iLoad_key && iLoad_msg;
   assign key_clr   = loading && (state_q == LOAD_KEY) && !iLoad_key;
   assign msg_clr   = loading && (state_q == LOAD_MSG) && !iLoad_msg;
   assign cipher    = msg_word ^ key_word;

   sipo_loader #(
      .WIDTH(WIDTH)
   ) u_key (
      .clk  (iClk),
      .rst  (iRst),
      .shift(key_shift),
      .clear(key_clr),
      .din  (iSerial_in),
      .word (key_word),
      .full (key_full)
   );

   sipo_loader #(
      .WIDTH(WIDTH)
   ) u_msg (
      .clk  (iClk),
      .rst  (iRst),
      .shift(msg_shift),
      .clear(msg_clr),
      .din  (iSerial_in),
      .word (msg_word),
      .full (msg_full)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      key_valid_d = key_valid_q;
      out_d       = out_q;
      start_d     = start_q;
      end_d       = end_q;
      if (iEn) begin
         out_d   = 1'b0;
         start_d = 1'b0;
         end_d   = 1'b0;
         if (state_q == EMIT) begin
            out_d   = cipher[LAST - idx_q];
            start_d = (idx_q == '0);
            end_d   = (idx_q == LAST);
            if (idx_q == LAST) begin
               state_d = IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + CW'(1);
            end
         end else begin
            state_d = IDLE;
            if (key_clr) begin
               key_valid_d = 1'b0;
            end
            if (key_shift) begin
               state_d = LOAD_KEY;
               if (key_full) begin
                  key_valid_d = 1'b1;
                  state_d     = IDLE;
               end
            end else if (msg_shift) begin
               state_d = LOAD_MSG;
               idx_d   = '0;
               if (msg_full) begin
                  state_d = key_valid_d ? EMIT : IDLE;
               end
            end
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         key_valid_q <= 1'b0;
         out_q       <= 1'b0;
         start_q     <= 1'b0;
         end_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         key_valid_q <= key_valid_d;
         out_q       <= out_d;
         start_q     <= start_d;
         end_q       <= end_d;
      end
   end

   assign oSerial_out   = out_q;
   assign oSerial_start = start_q;
   assign oSerial_end   = end_q;

endmodule

// File: tb/tb_franco_xor_top.sv
// Directed bench for franco_xor_top: key/message loads, emitted streams, enable stalls,
// load priority, aborts and resets.
module tb_franco_xor_top;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst, en, load_key, load_msg, din;
   logic out_bit, start_bit, end_bit;
   int   n_checks = 0;
   int   n_fail = 0;

   franco_xor_top #(
      .WIDTH(W)
   ) dut (
      .iClk         (clk),
      .iRst         (rst),
      .iEn          (en),
      .iLoad_key    (load_key),
      .iLoad_msg    (load_msg),
      .iSerial_in   (din),
      .oSerial_out  (out_bit),
      .oSerial_start(start_bit),
      .oSerial_end  (end_bit)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic k, input logic m, input logic [W-1:0] v);
      for (int i = W - 1; i >= 0; i--) begin
         load_key = k;
         load_msg = m;
         din      = v[i];
         tick();
      end
      load_key = 1'b0;
      load_msg = 1'b0;
      din      = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; load_key = 1'b0; load_msg = 1'b0; din = 1'b0;
      tick();
      en = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if ({out_bit, start_bit, end_bit} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want 000", {out_bit, start_bit, end_bit});
      end
   endtask

   task automatic test_basic();
      logic [W-1:0] c;
      logic [2:0]   exp;
      c = 8'h99;
      load_word(1'b1, 1'b0, 8'hA5);
      load_word(1'b0, 1'b1, 8'h3C);
      n_checks++;
      if ({out_bit, start_bit, end_bit} !== 3'b000) begin
         n_fail++;
         $display("FAIL basic_latency: got %b want 000", {out_bit, start_bit, end_bit});
      end
      for (int k = 0; k < W; k++) begin
         tick();
         exp = {c[W-1-k], (k == 0), (k == W - 1)};
         n_checks++;
         if ({out_bit, start_bit, end_bit} !== exp) begin
            n_fail++;
            $display("FAIL basic_bit%0d: got %b want %b", k, {out_bit, start_bit, end_bit}, exp);
         end
      end
      tick();
      n_checks++;
      if ({out_bit, start_bit, end_bit} !== 3'b000) begin
         n_fail++;
         $display("FAIL basic_after: got %b want 000", {out_bit, start_bit, end_bit});
      end
   endtask

   task automatic test_key_retention();
      logic [W-1:0] c;
      logic [2:0]   exp;
      c = 8'h5A;
      load_word(1'b0, 1'b1, 8'hFF);
      for (int k = 0; k < W; k++) begin
         tick();
         exp = {c[W-1-k], (k == 0), (k == W - 1)};
         n_checks++;
         if ({out_bit, start_bit, end_bit} !== exp) begin
            n_fail++;
            $display("FAIL retain_bit%0d: got %b want %b", k, {out_bit, start_bit, end_bit}, exp);
         end
      end
      tick();
      n_checks++;
      if ({out_bit, start_bit, end_bit} !== 3'b000) begin
         n_fail++;
         $display("FAIL retain_after: got %b want 000", {out_bit, start_bit, end_bit});
      end
   endtask

   task automatic test_key_abort();
      for (int i = 0; i < 4; i++) begin
         load_key = 1'b1;
         din      = 1'b1;
         tick();
      end
      load_key = 1'b0;
      din      = 1'b0;
      tick();
      load_word(1'b0, 1'b1, 8'h3C);
      for (int k = 0; k < 2 * W; k++) begin
         tick();
         n_checks++;
         if ({out_bit, start_bit, end_bit} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_quiet%0d: got %b want 000", k, {out_bit, start_bit, end_bit});
         end
      end
   endtask

   task automatic test_enable_stall();
      logic [W-1:0] c;
      logic [2:0]   exp;
      c = 8'h99;
      load_word(1'b1, 1'b0, 8'hA5);
      load_word(1'b0, 1'b1, 8'h3C);
      for (int k = 0; k < W; k++) begin
         tick();
         exp = {c[W-1-k], (k == 0), (k == W - 1)};
         n_checks++;
         if ({out_bit, start_bit, end_bit} !== exp) begin
            n_fail++;
            $display("FAIL stall_bit%0d: got %b want %b", k, {out_bit, start_bit, end_bit}, exp);
         end
         if (k == 3) begin
            en = 1'b0;
            for (int h = 0; h < 3; h++) begin
               tick();
               n_checks++;
               if ({out_bit, start_bit, end_bit} !== exp) begin
                  n_fail++;
                  $display("FAIL stall_hold%0d: got %b want %b", h,
                           {out_bit, start_bit, end_bit}, exp);
               end
            end
            en = 1'b1;
         end
      end
      tick();
      n_checks++;
      if ({out_bit, start_bit, end_bit} !== 3'b000) begin
         n_fail++;
         $display("FAIL stall_after: got %b want 000", {out_bit, start_bit, end_bit});
      end
   endtask

   task automatic test_load_priority();
      logic [W-1:0] c;
      logic [2:0]   exp;
      c = 8'hA5;
      load_word(1'b1, 1'b0, 8'h0F);
      load_word(1'b1, 1'b1, 8'hA5);
      // A shifted message here would have emitted with the valid key.
      for (int k = 0; k < W; k++) begin
         tick();
         n_checks++;
         if ({out_bit, start_bit, end_bit} !== 3'b000) begin
            n_fail++;
            $display("FAIL prio_quiet%0d: got %b want 000", k, {out_bit, start_bit, end_bit});
         end
      end
      load_word(1'b0, 1'b1, 8'h00);
      for (int k = 0; k < W; k++) begin
         tick();
         exp = {c[W-1-k], (k == 0), (k == W - 1)};
         n_checks++;
         if ({out_bit, start_bit, end_bit} !== exp) begin
            n_fail++;
            $display("FAIL prio_bit%0d: got %b want %b", k, {out_bit, start_bit, end_bit}, exp);
         end
      end
      tick();
   endtask

   task automatic test_no_key();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      load_word(1'b0, 1'b1, 8'h3C);
      for (int k = 0; k < 2 * W; k++) begin
         tick();
         n_checks++;
         if ({out_bit, start_bit, end_bit} !== 3'b000) begin
            n_fail++;
            $display("FAIL nokey_quiet%0d: got %b want 000", k, {out_bit, start_bit, end_bit});
         end
      end
   endtask

   task automatic test_reset_mid_emit();
      load_word(1'b1, 1'b0, 8'hA5);
      load_word(1'b0, 1'b1, 8'h3C);
      tick();
      n_checks++;
      if ({out_bit, start_bit, end_bit} !== 3'b110) begin
         n_fail++;
         $display("FAIL midrst_first: got %b want 110", {out_bit, start_bit, end_bit});
      end
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if ({out_bit, start_bit, end_bit} !== 3'b000) begin
         n_fail++;
         $display("FAIL midrst_zero: got %b want 000", {out_bit, start_bit, end_bit});
      end
      load_word(1'b0, 1'b1, 8'h3C);
      for (int k = 0; k < 2 * W; k++) begin
         tick();
         n_checks++;
         if ({out_bit, start_bit, end_bit} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_quiet%0d: got %b want 000", k, {out_bit, start_bit, end_bit});
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_key_retention();
      test_key_abort();
      test_enable_stall();
      test_load_priority();
      test_no_key();
      test_reset_mid_emit();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
